// File: rtl/bus_term_ctrl.sv
// Bus-cycle termination: merges per-source DSACK pairs, times out unanswered cycles to BERR.
// Optional autovector answer for IACK cycles when BUSTERM_AUTOVEC_EN is defined.
module bus_term_ctrl #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 250,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned AVEC_DELAY     = 2
) (
    input  logic                   sysClk,
    input  logic                   nReset,
    input  logic                   nAS,
    input  logic [2:0]             cpuFC,
    input  logic [2*NUM_SRC-1:0]   srcDsack,
    input  logic                   clrStatus,
    output logic [1:0]             nDsack,
    output logic                   nBerr,
    output logic                   nAvec,
    output logic                   timeoutFlag,
    output logic [7:0]             berrCount
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StActive = 3'd1,
        StTerm   = 3'd2,
        StBerr   = 3'd3,
        StEnd    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dsack_q, dsack_d;
    logic             berr_q, berr_d;
    logic             flag_q, flag_d;
    logic [7:0]       count_q, count_d;
    logic [1:0]       merged_dsack;

`ifdef BUSTERM_AUTOVEC_EN
    localparam logic [CNT_W-1:0] AvecLast = CNT_W'(AVEC_DELAY - 1);
    logic avec_q, avec_d;
`else
    logic unused_avec;
    assign unused_avec = ^{cpuFC, 1'(AVEC_DELAY)};
`endif

    // Any source pulling a bit low pulls the CPU bit low.
    always_comb begin
        merged_dsack = 2'b11;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            merged_dsack = merged_dsack & srcDsack[2*i +: 2];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dsack_d = 2'b11;
        berr_d  = 1'b1;
        flag_d  = flag_q;
        count_d = count_q;
`ifdef BUSTERM_AUTOVEC_EN
        avec_d  = 1'b1;
`endif
        if (clrStatus) begin
            flag_d  = 1'b0;
            count_d = 8'h00;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!nAS) state_d = StActive;
            end
            StActive: begin
                if (nAS) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (merged_dsack != 2'b11) begin
                    state_d = StTerm;
                    dsack_d = merged_dsack;
`ifdef BUSTERM_AUTOVEC_EN
                end else if (cpuFC == 3'b111 && cnt_q == AvecLast) begin
                    state_d = StTerm;
                    avec_d  = 1'b0;
`endif
                end else if (cnt_q == TimeoutLast) begin
                    // Counter is held here; a coincident clear still leaves count = 1.
                    state_d = StBerr;
                    berr_d  = 1'b0;
                    flag_d  = 1'b1;
                    count_d = clrStatus ? 8'h01 :
                              (count_q == 8'hFF) ? 8'hFF : count_q + 8'h01;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StTerm: begin
                if (nAS) begin
                    state_d = StIdle;
                end else begin
                    dsack_d = merged_dsack;
`ifdef BUSTERM_AUTOVEC_EN
                    avec_d  = avec_q;
`endif
                end
            end
            StBerr: begin
                if (nAS) state_d = StIdle;
                else     berr_d  = 1'b0;
            end
            StEnd: begin
                if (nAS) state_d = StIdle;
            end
            default: state_d = StEnd;
        endcase
    end

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StEnd;
            cnt_q   <= '0;
            dsack_q <= 2'b11;
            berr_q  <= 1'b1;
            flag_q  <= 1'b0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dsack_q <= dsack_d;
            berr_q  <= berr_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

`ifdef BUSTERM_AUTOVEC_EN
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) avec_q <= 1'b1;
        else         avec_q <= avec_d;
    end
    assign nAvec = avec_q;
`else
    assign nAvec = 1'b1;
`endif

    assign nDsack      = dsack_q;
    assign nBerr       = berr_q;
    assign timeoutFlag = flag_q;
    assign berrCount   = count_q;

endmodule

// File: tb/tb_bus_term_ctrl.sv
// Self-checking bench for bus_term_ctrl: a per-cycle outcome model predicts termination edges.
module tb_bus_term_ctrl;

    localparam int unsigned NUM_SRC  = 3;
    localparam int          TIMEOUT  = 250;
    localparam int          AVEC_DLY = 2;
    localparam int          NEVER    = 100000;

    logic                 sysClk = 1'b0;
    logic                 nReset;
    logic                 nAS;
    logic [2:0]           cpuFC;
    logic [2*NUM_SRC-1:0] srcDsack;
    logic                 clrStatus;
    logic [1:0]           nDsack;
    logic                 nBerr;
    logic                 nAvec;
    logic                 timeoutFlag;
    logic [7:0]           berrCount;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_flag;
    logic [7:0] exp_cnt;

    always #5 sysClk = ~sysClk;

    bus_term_ctrl #(
        .NUM_SRC       (NUM_SRC),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (8),
        .AVEC_DELAY    (AVEC_DLY)
    ) dut (
        .sysClk     (sysClk),
        .nReset     (nReset),
        .nAS        (nAS),
        .cpuFC      (cpuFC),
        .srcDsack   (srcDsack),
        .clrStatus  (clrStatus),
        .nDsack     (nDsack),
        .nBerr      (nBerr),
        .nAvec      (nAvec),
        .timeoutFlag(timeoutFlag),
        .berrCount  (berrCount)
    );

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    function automatic logic [1:0] merge_pairs(input logic [2*NUM_SRC-1:0] v);
        logic [1:0] m;
        m = 2'b11;
        for (int i = 0; i < int'(NUM_SRC); i++) m = m & v[2*i +: 2];
        return m;
    endfunction

    // One CPU bus cycle: nAS low for `hold` edges after the sampling edge, then one high edge.
    // Outcome per cycle: 1 = DSACK, 2 = timeout BERR, 3 = autovector.
    task automatic bus_cycle(input string name, input int dsack_win,
                             input logic [2*NUM_SRC-1:0] resp, input logic [2:0] fc,
                             input int hold, input int clr_win);
        logic [1:0] merged, e_dsack;
        logic       e_berr, e_avec;
        int         kind, term_edge;
        merged    = merge_pairs(resp);
        kind      = 0;
        term_edge = NEVER;
        if (merged != 2'b11 && dsack_win < TIMEOUT) begin
            kind      = 1;
            term_edge = dsack_win + 1;
        end
`ifdef BUSTERM_AUTOVEC_EN
        if (fc == 3'b111 && !(kind == 1 && term_edge <= AVEC_DLY)) begin
            kind      = 3;
            term_edge = AVEC_DLY;
        end
`endif
        if (kind == 0) begin
            kind      = 2;
            term_edge = TIMEOUT;
        end
        cpuFC    = fc;
        nAS      = 1'b0;
        srcDsack = '1;
        tick();
        for (int e = 1; e <= hold; e++) begin
            srcDsack  = (e - 1 >= dsack_win && kind != 3) ? resp : '1;
            clrStatus = (e - 1 == clr_win);
            tick();
            if (clr_win == e - 1) begin
                exp_flag = 1'b0;
                exp_cnt  = 8'h00;
            end
            if (kind == 2 && e == term_edge) begin
                exp_flag = 1'b1;
                if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
            end
            e_dsack = (kind == 1 && e >= term_edge) ? merged : 2'b11;
            e_berr  = !(kind == 2 && e >= term_edge);
            e_avec  = !(kind == 3 && e >= term_edge);
            n_checks += 5;
            if (nDsack !== e_dsack) begin
                n_fail++;
                $display("FAIL %s edge %0d nDsack got %b want %b", name, e, nDsack, e_dsack);
            end
            if (nBerr !== e_berr) begin
                n_fail++;
                $display("FAIL %s edge %0d nBerr got %b want %b", name, e, nBerr, e_berr);
            end
            if (nAvec !== e_avec) begin
                n_fail++;
                $display("FAIL %s edge %0d nAvec got %b want %b", name, e, nAvec, e_avec);
            end
            if (timeoutFlag !== exp_flag) begin
                n_fail++;
                $display("FAIL %s edge %0d timeoutFlag got %b want %b", name, e, timeoutFlag,
                         exp_flag);
            end
            if (berrCount !== exp_cnt) begin
                n_fail++;
                $display("FAIL %s edge %0d berrCount got %0d want %0d", name, e, berrCount,
                         exp_cnt);
            end
        end
        clrStatus = 1'b0;
        nAS       = 1'b1;
        srcDsack  = '1;
        tick();
        n_checks += 3;
        if ({nDsack, nBerr, nAvec} !== 4'b1111) begin
            n_fail++;
            $display("FAIL %s release outputs got %b want 1111", name, {nDsack, nBerr, nAvec});
        end
        if (timeoutFlag !== exp_flag) begin
            n_fail++;
            $display("FAIL %s release timeoutFlag got %b want %b", name, timeoutFlag, exp_flag);
        end
        if (berrCount !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s release berrCount got %0d want %0d", name, berrCount, exp_cnt);
        end
    endtask

    task automatic test_reset();
        nReset    = 1'b0;
        nAS       = 1'b1;
        cpuFC     = 3'b000;
        srcDsack  = '1;
        clrStatus = 1'b0;
        exp_flag  = 1'b0;
        exp_cnt   = 8'h00;
        #12;
        n_checks++;
        if ({nDsack, nBerr, nAvec, timeoutFlag, berrCount} !== {4'b1111, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset outputs got %b/%b/%b/%b/%0d want 11/1/1/0/0",
                     nDsack, nBerr, nAvec, timeoutFlag, berrCount);
        end
        @(negedge sysClk);
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_acia_dsack();
        bus_cycle("acia_dsack", 19, 6'b11_11_10, 3'b101, 40, -1);
    endtask

    task automatic test_timeout();
        bus_cycle("timeout", NEVER, '1, 3'b001, 300, -1);
    endtask

    task automatic test_dsack_at_timeout();
        bus_cycle("dsack_at_timeout", TIMEOUT - 1, 6'b01_11_11, 3'b010, 260, -1);
    endtask

    task automatic test_clear();
        clrStatus = 1'b1;
        tick();
        clrStatus = 1'b0;
        exp_flag  = 1'b0;
        exp_cnt   = 8'h00;
        n_checks++;
        if ({timeoutFlag, berrCount} !== 9'h000) begin
            n_fail++;
            $display("FAIL clear got flag %b count %0d want 0 0", timeoutFlag, berrCount);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [2*NUM_SRC-1:0] resp;
            logic [2:0]           fc;
            int                   idx, win, hold, mode;
            fc   = 3'($urandom_range(0, 7));
            resp = '1;
            for (int s = 0; s < int'(NUM_SRC); s++)
                if ($urandom_range(0, 3) == 0) resp[2*s +: 2] = 2'($urandom_range(0, 3));
            idx  = $urandom_range(0, NUM_SRC - 1);
            resp[2*idx +: 2] = 2'($urandom_range(0, 2));
            mode = $urandom_range(0, 3);
            if (mode <= 1) begin
                win  = $urandom_range(0, 60);
                hold = win + $urandom_range(1, 20);
            end else if (mode == 2) begin
                win  = NEVER;
                hold = $urandom_range(251, 255);
            end else begin
                win  = NEVER;
                hold = $urandom_range(1, 100);
            end
`ifdef BUSTERM_AUTOVEC_EN
            if (fc == 3'b111 && win > 1) win = NEVER;
`endif
            bus_cycle("random", win, resp, fc, hold, -1);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) bus_cycle("saturate", NEVER, '1, 3'b000, 251, -1);
        n_checks++;
        if (berrCount !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation berrCount got %0d want 255", berrCount);
        end
        test_clear();
        bus_cycle("clr_coincide", NEVER, '1, 3'b000, 251, TIMEOUT - 1);
        n_checks++;
        if ({timeoutFlag, berrCount} !== {1'b1, 8'h01}) begin
            n_fail++;
            $display("FAIL clr_coincide got flag %b count %0d want 1 1", timeoutFlag, berrCount);
        end
    endtask

    task automatic test_reset_mid_cycle();
        cpuFC    = 3'b000;
        nAS      = 1'b0;
        srcDsack = '1;
        for (int i = 0; i < 10; i++) tick();
        #2;
        nReset   = 1'b0;
        exp_flag = 1'b0;
        exp_cnt  = 8'h00;
        #1;
        n_checks++;
        if ({nDsack, nBerr, nAvec, timeoutFlag, berrCount} !== {4'b1111, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL mid_reset outputs got %b/%b/%b/%b/%0d want 11/1/1/0/0",
                     nDsack, nBerr, nAvec, timeoutFlag, berrCount);
        end
        @(posedge sysClk);
        #3;
        nReset = 1'b1;
        for (int e = 0; e < 300; e++) begin
            srcDsack = (e >= 5 && e < 40) ? 6'b11_00_11 : '1;
            tick();
            n_checks++;
            if ({nDsack, nBerr, nAvec} !== 4'b1111) begin
                n_fail++;
                $display("FAIL mid_reset hold edge %0d got %b want 1111", e,
                         {nDsack, nBerr, nAvec});
            end
        end
        nAS      = 1'b1;
        srcDsack = '1;
        tick();
        bus_cycle("after_reset", 7, 6'b10_11_11, 3'b011, 15, -1);
    endtask

    task automatic test_iack();
        bus_cycle("iack", NEVER, '1, 3'b111, 300, -1);
        bus_cycle("iack_dsack_wins", 1, 6'b11_11_00, 3'b111, 10, -1);
    endtask

    initial begin
        test_reset();
        test_acia_dsack();
        test_timeout();
        test_dsack_at_timeout();
        test_clear();
        test_random();
        test_saturation();
        test_reset_mid_cycle();
        test_iack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
